// File: rtl/clock_set_pkg.sv
// clock_set_pkg: shared types and default constants for the time-set controller.
//   state_e : controller FSM states (IDLE/PRESS/SLOW/FAST)
//   sel_e   : which button owns the current set sequence
//   DEF_*   : default parameter values
//   max_int : helper used to size the hold counter
package clock_set_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_SLOW  = 2'd2,
        ST_FAST  = 2'd3
    } state_e;

    typedef enum logic {
        SEL_HOURS   = 1'b0,
        SEL_MINUTES = 1'b1
    } sel_e;

    localparam int DEF_DEBOUNCE_CNT   = 16;
    localparam int DEF_HOLD_SLOW_SECS = 2;
    localparam int DEF_HOLD_FAST_SECS = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clock_set_ctrl_debounce.sv
// btn_debounce: 2-flop synchronizer + strobe-based debouncer for one button.
//   i_clk, i_reset   : clock, synchronous active-high reset
//   i_debounce_stb   : debounce sample strobe
//   i_btn            : raw asynchronous button level
//   o_rise, o_fall   : one-cycle pulses, asserted on the cycle the stable
//                      level is seen changed (registered alongside it)
module btn_debounce
    import clock_set_pkg::*;
#(
    parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_debounce_stb,
    input  logic i_btn,
    output logic o_rise,
    output logic o_fall
);

    localparam int CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;

    logic          sync1_q, sync2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;
    logic          rise_q, fall_q;

    // Any strobe where the synced level agrees with the stable level restarts
    // the run, so only DEBOUNCE_CNT consecutive disagreeing strobes flip it.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (i_debounce_stb) begin
            if (cnt_q == CW'(DEBOUNCE_CNT - 1)) begin
                stable_d = ~stable_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync1_q  <= i_btn;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= stable_d & ~stable_q;
            fall_q   <= ~stable_d & stable_q;
        end
    end

    assign o_rise = rise_q;
    assign o_fall = fall_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: turns held hours/minutes set buttons into increment pulses.
// One pulse on press, 2 Hz repeat after HOLD_SLOW_SECS, 8 Hz repeat after a
// further HOLD_FAST_SECS (FAST phase only when CLOCK_SET_FAST_EN is defined;
// otherwise SLOW is terminal).
//   i_clk, i_reset                  : clock, synchronous active-high reset
//   i_1hz_stb, i_slow_set_stb,
//   i_fast_set_stb, i_debounce_stb  : single-cycle rate strobes
//   i_btn_hours, i_btn_minutes      : raw asynchronous buttons, active-high
//   o_inc_hours, o_inc_minutes      : registered single-cycle increment pulses
//   o_set_active                    : FSM is not IDLE
module clock_set_ctrl
    import clock_set_pkg::*;
#(
    parameter int DEBOUNCE_CNT   = DEF_DEBOUNCE_CNT,
    parameter int HOLD_SLOW_SECS = DEF_HOLD_SLOW_SECS,
    parameter int HOLD_FAST_SECS = DEF_HOLD_FAST_SECS
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_1hz_stb,
    input  logic i_slow_set_stb,
    input  logic i_fast_set_stb,
    input  logic i_debounce_stb,
    input  logic i_btn_hours,
    input  logic i_btn_minutes,
    output logic o_inc_hours,
    output logic o_inc_minutes,
    output logic o_set_active
);

`ifdef CLOCK_SET_FAST_EN
    localparam int HOLD_TOP = max_int(HOLD_SLOW_SECS, HOLD_FAST_SECS);
`else
    localparam int HOLD_TOP = HOLD_SLOW_SECS;
    logic unused_fast;
    assign unused_fast = i_fast_set_stb;
`endif
    localparam int HW = $clog2(HOLD_TOP + 1);

    logic h_rise, h_fall, m_rise, m_fall;

    btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db_hours (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_debounce_stb (i_debounce_stb),
        .i_btn          (i_btn_hours),
        .o_rise         (h_rise),
        .o_fall         (h_fall)
    );

    btn_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_db_minutes (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_debounce_stb (i_debounce_stb),
        .i_btn          (i_btn_minutes),
        .o_rise         (m_rise),
        .o_fall         (m_fall)
    );

    state_e        state_q, state_d;
    sel_e          sel_q, sel_d;
    logic [HW-1:0] hold_q, hold_d, hold_inc;
    logic          inc_h_q, inc_h_d, inc_m_q, inc_m_d;
    logic          sel_fall, pulse;

    assign sel_fall = (sel_q == SEL_HOURS) ? h_fall : m_fall;
    assign hold_inc = (hold_q == HW'(HOLD_TOP)) ? hold_q : hold_q + HW'(1);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        hold_d  = hold_q;
        pulse   = 1'b0;
        inc_h_d = 1'b0;
        inc_m_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                hold_d = '0;
                // Only a fresh rise starts a press; hours wins a tie.
                if (h_rise) begin
                    state_d = ST_PRESS;
                    sel_d   = SEL_HOURS;
                    inc_h_d = 1'b1;
                end else if (m_rise) begin
                    state_d = ST_PRESS;
                    sel_d   = SEL_MINUTES;
                    inc_m_d = 1'b1;
                end
            end
            ST_PRESS: begin
                if (sel_fall) begin
                    state_d = ST_IDLE;
                end else if (i_1hz_stb) begin
                    if (hold_q == HW'(HOLD_SLOW_SECS - 1)) begin
                        state_d = ST_SLOW;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_inc;
                    end
                end
            end
            ST_SLOW: begin
                if (sel_fall) begin
                    state_d = ST_IDLE;
                end else begin
                    pulse = i_slow_set_stb;
`ifdef CLOCK_SET_FAST_EN
                    if (i_1hz_stb) begin
                        if (hold_q == HW'(HOLD_FAST_SECS - 1)) begin
                            state_d = ST_FAST;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_inc;
                        end
                    end
`endif
                end
            end
`ifdef CLOCK_SET_FAST_EN
            ST_FAST: begin
                if (sel_fall) state_d = ST_IDLE;
                else          pulse   = i_fast_set_stb;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (pulse) begin
            inc_h_d = (sel_q == SEL_HOURS);
            inc_m_d = (sel_q == SEL_MINUTES);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_HOURS;
            hold_q  <= '0;
            inc_h_q <= 1'b0;
            inc_m_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
            inc_h_q <= inc_h_d;
            inc_m_q <= inc_m_d;
        end
    end

    assign o_inc_hours   = inc_h_q;
    assign o_inc_minutes = inc_m_q;
    assign o_set_active  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed + randomized checks of clock_set_ctrl with
// DEBOUNCE_CNT=4, HOLD_SLOW_SECS=2, HOLD_FAST_SECS=3. Expectations for the
// FAST phase follow CLOCK_SET_FAST_EN.
module tb_clock_set_ctrl;

`ifdef CLOCK_SET_FAST_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif
    localparam int HS = 2;
    localparam int HF = 3;

    logic clk = 1'b0;
    logic rst, hz, slow, fast, deb, bh, bm;
    logic inc_h, inc_m, act;

    int errors = 0;
    int checks = 0;
    int nh = 0, nm = 0, both = 0;

    clock_set_ctrl #(
        .DEBOUNCE_CNT   (4),
        .HOLD_SLOW_SECS (HS),
        .HOLD_FAST_SECS (HF)
    ) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_1hz_stb      (hz),
        .i_slow_set_stb (slow),
        .i_fast_set_stb (fast),
        .i_debounce_stb (deb),
        .i_btn_hours    (bh),
        .i_btn_minutes  (bm),
        .o_inc_hours    (inc_h),
        .o_inc_minutes  (inc_m),
        .o_set_active   (act)
    );

    always #5 clk = ~clk;

    // Pulses are registered single-cycle, so one sample per cycle counts them.
    always @(negedge clk) begin
        if (inc_h) nh++;
        if (inc_m) nm++;
        if (inc_h && inc_m) both++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic strobes(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd) repeat ($urandom_range(0, 3)) cyc();
            deb = 1'b1;
            cyc();
            deb = 1'b0;
        end
    endtask

    // Change a raw level and let it propagate through sync + debounce.
    task automatic settle(input int n, input bit rnd);
        cyc();
        cyc();
        strobes(n, rnd);
        cyc();
        cyc();
    endtask

    task automatic tick(input bit t_hz, input bit t_slow, input bit t_fast);
        hz = t_hz; slow = t_slow; fast = t_fast;
        cyc();
        hz = 1'b0; slow = 1'b0; fast = 1'b0;
    endtask

    // Reference: phase depends only on how many 1 Hz strobes have passed
    // since the press was accepted.
    function automatic int exp_pulse(input int secs, input bit s, input bit f);
        if (secs < HS) return 0;
        if (FAST_EN && secs >= HS + HF) return f ? 1 : 0;
        return s ? 1 : 0;
    endfunction

    int h0, m0, secs, expn;

    initial begin
        rst = 1'b1; hz = 0; slow = 0; fast = 0; deb = 0; bh = 0; bm = 0;
        cyc(); cyc();
        chk("reset_inc_h", inc_h, 0);
        chk("reset_inc_m", inc_m, 0);
        chk("reset_active", act, 0);
        rst = 1'b0;
        cyc();

        // Tap hours: exact pulse timing after the debounced rise.
        h0 = nh;
        bh = 1'b1;
        cyc(); cyc(); cyc();
        strobes(4, 1'b0);           // 4th strobe edge registers the rise
        chk("tap_no_early_pulse", inc_h, 0);
        cyc();
        chk("tap_pulse_cycle", inc_h, 1);
        chk("tap_active", act, 1);
        cyc();
        chk("tap_pulse_width", inc_h, 0);
        strobes(6, 1'b0);
        bh = 1'b0;
        settle(4, 1'b1);
        chk("tap_pulse_count", nh - h0, 1);
        chk("tap_release_active", act, 0);

        // Minutes glitch for 3 strobes.
        m0 = nm;
        bm = 1'b1;
        cyc(); cyc();
        strobes(3, 1'b0);
        bm = 1'b0;
        settle(5, 1'b1);
        chk("glitch_pulses", nm - m0, 0);
        chk("glitch_active", act, 0);

        // Directed hold on minutes: PRESS, SLOW, then FAST (if built).
        m0 = nm; h0 = nh;
        bm = 1'b1;
        settle(4, 1'b1);
        for (int i = 0; i < 4; i++) begin tick(0, 0, 1); cyc(); end
        tick(1, 0, 0); cyc();
        for (int i = 0; i < 2; i++) begin tick(0, 0, 1); cyc(); end
        tick(1, 0, 0); cyc();
        for (int i = 0; i < 4; i++) begin tick(0, 1, 0); tick(0, 0, 1); end
        cyc(); cyc();
        chk("hold_slow_pulses", nm - m0, 5);
        for (int i = 0; i < 3; i++) begin tick(1, 0, 0); cyc(); end
        for (int i = 0; i < 8; i++) begin tick(0, 0, 1); cyc(); end
        cyc(); cyc();
        chk("hold_fast_pulses", nm - m0, FAST_EN ? 13 : 5);
        chk("hold_hours_quiet", nh - h0, 0);
        chk("hold_active", act, 1);
        bm = 1'b0;
        settle(4, 1'b1);
        chk("hold_release_active", act, 0);

        // Randomized hold on hours against the phase model.
        for (int run = 0; run < 2; run++) begin
            h0 = nh; m0 = nm;
            bh = 1'b1;
            settle(4, 1'b1);
            chk("rnd_press_pulse", nh - h0, 1);
            secs = 0; expn = 1;
            for (int c = 0; c < 700; c++) begin
                hz   = ($urandom_range(0, 39) == 0);
                slow = ($urandom_range(0, 5) == 0);
                fast = ($urandom_range(0, 2) == 0);
                expn += exp_pulse(secs, slow, fast);
                if (hz) secs++;
                cyc();
            end
            hz = 0; slow = 0; fast = 0;
            cyc(); cyc();
            chk("rnd_hold_pulses", nh - h0, expn);
            chk("rnd_minutes_quiet", nm - m0, 0);
            bh = 1'b0;
            settle(4, 1'b1);
            chk("rnd_release_active", act, 0);
        end

        // Simultaneous rise: hours wins; minutes release is ignored.
        h0 = nh; m0 = nm;
        bh = 1'b1; bm = 1'b1;
        settle(4, 1'b1);
        chk("tie_hours", nh - h0, 1);
        chk("tie_minutes", nm - m0, 0);
        bm = 1'b0;
        settle(6, 1'b1);
        chk("tie_minutes_release_active", act, 1);
        chk("tie_minutes_release_pulses", nm - m0, 0);
        bh = 1'b0;
        settle(4, 1'b1);
        chk("tie_release_active", act, 0);

        // Reset while in SLOW with a slow strobe present.
        bh = 1'b1;
        settle(4, 1'b1);
        tick(1, 0, 0); tick(1, 0, 0); cyc();
        h0 = nh;
        rst = 1'b1; slow = 1'b1;
        cyc();
        chk("rst_no_pulse", inc_h, 0);
        chk("rst_idle", act, 0);
        slow = 1'b0;
        cyc();
        rst = 1'b0;
        cyc(); cyc();
        strobes(3, 1'b1);
        cyc(); cyc();
        chk("rst_no_early_press", nh - h0, 0);
        strobes(1, 1'b1);
        cyc(); cyc();
        chk("rst_fresh_press", nh - h0, 1);
        chk("rst_fresh_active", act, 1);
        bh = 1'b0;
        settle(4, 1'b1);
        chk("rst_release_active", act, 0);

        chk("never_both", both, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
